// File: rtl/pix_conf_pkg.sv
// rtl/pix_conf_pkg.sv - shared types and constants for the pixel configuration master
package pix_conf_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  // Pixel address layout: {row, region, pixel}
  localparam int ROW_W      = 6;
  localparam int ROW_OFF    = 6;
  localparam int REGION_W   = 4;
  localparam int REGION_OFF = 2;
  localparam int PIXEL_W    = 2;
  localparam int PIXEL_OFF  = 0;

  localparam logic [ADDR_W-1:0] BROADCAST_ADDR = 12'hFFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    HOLD    = 3'd3,
    SETTLE  = 3'd4,
    CAPTURE = 3'd5,
    RESP    = 3'd6
  } conf_state_t;

  function automatic logic is_broadcast(input logic [ADDR_W-1:0] addr);
    return addr == BROADCAST_ADDR;
  endfunction

endpackage

// File: rtl/pix_conf_if.sv
// rtl/pix_conf_if.sv - request/response handshake between a requester and the configuration master
interface pix_conf_if;
  import pix_conf_pkg::*;

  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic [ADDR_W-1:0] ReqAddr;
  logic [DATA_W-1:0] ReqData;
  logic              RspValid;
  logic [DATA_W-1:0] RspData;
  logic              RspErr;

  // Requester side
  modport master (
    output ReqValid, ReqWrite, ReqAddr, ReqData,
    input  ReqReady, RspValid, RspData, RspErr
  );

  // Configuration master side
  modport slave (
    input  ReqValid, ReqWrite, ReqAddr, ReqData,
    output ReqReady, RspValid, RspData, RspErr
  );

endinterface

// File: rtl/pix_conf_timer.sv
// rtl/pix_conf_timer.sv - loadable 4-bit down-counter with zero flag for strobe/settle timing
module pix_conf_timer
  import pix_conf_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load has priority; decrement stops at zero so the count never wraps
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pix_conf_master.sv
// rtl/pix_conf_master.sv - pixel configuration bus master; PIX_CONF_VERIFY_EN adds write readback verify
module pix_conf_master
  import pix_conf_pkg::*;
#(
  parameter int                WR_PULSE_CYC  = 2,
  parameter int                RD_SETTLE_CYC = 4,
  parameter logic [DATA_W-1:0] DATA_MASK     = 8'h07
)(
  input  logic              Clk,
  input  logic              Reset,
  pix_conf_if.slave         bus,
  output logic [ADDR_W-1:0] AddressConfOut,
  output logic [DATA_W-1:0] DataConfWrOut,
  output logic              ConfWrOut,
  input  logic [DATA_W-1:0] DataConfRdIn,
  output logic              Busy
);

`ifdef PIX_CONF_VERIFY_EN
  localparam bit VERIFY_EN = 1'b1;
`else
  localparam bit VERIFY_EN = 1'b0;
`endif

  // Timer counts N-1 down to 0, so a state held for N cycles loads N-1
  localparam logic [CNT_W-1:0] WR_LOAD = 4'(WR_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = 4'(RD_SETTLE_CYC - 1);

  conf_state_t       state;
  logic              lat_write;
  logic              lat_bcast;
  logic              req_ready;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_data;

  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_dec;
  logic              tmr_zero;
  logic              mismatch;

  assign bus.ReqReady = req_ready;
  assign bus.RspValid = rsp_valid;
  assign bus.RspData  = rsp_data;
  assign bus.RspErr   = rsp_err;

  // Timer is loaded on the cycle before STROBE/SETTLE is entered and counts inside them
  assign tmr_load = (state == SETUP) || (state == HOLD);
  assign tmr_val  = ((state == SETUP) && lat_write) ? WR_LOAD : RD_LOAD;
  assign tmr_dec  = (state == STROBE) || (state == SETTLE);

  // Readback compares against the still-driven write data, only on masked bits
  assign mismatch = |((DataConfRdIn ^ DataConfWrOut) & DATA_MASK);

  pix_conf_timer u_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Main sequencer; every output is registered alongside the state transition
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= IDLE;
      lat_write      <= 1'b0;
      lat_bcast      <= 1'b0;
      req_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_err        <= 1'b0;
      rsp_data       <= '0;
      AddressConfOut <= '0;
      DataConfWrOut  <= '0;
      ConfWrOut      <= 1'b0;
      Busy           <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.ReqValid && req_ready) begin
            req_ready <= 1'b0;
            Busy      <= 1'b1;
            if (!bus.ReqWrite && is_broadcast(bus.ReqAddr)) begin
              // A broadcast read has no single source, so it fails without touching the bus
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
            end else begin
              state          <= SETUP;
              lat_write      <= bus.ReqWrite;
              lat_bcast      <= is_broadcast(bus.ReqAddr);
              AddressConfOut <= bus.ReqAddr;
              DataConfWrOut  <= bus.ReqData;
            end
          end
        end
        SETUP: begin
          if (lat_write) begin
            state     <= STROBE;
            ConfWrOut <= 1'b1;
          end else begin
            state <= SETTLE;
          end
        end
        STROBE: begin
          if (tmr_zero) begin
            state     <= HOLD;
            ConfWrOut <= 1'b0;
          end
        end
        HOLD: begin
          if (VERIFY_EN && !lat_bcast) begin
            state <= SETTLE;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
          end
        end
        SETTLE: begin
          if (tmr_zero) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_data  <= DataConfRdIn;
          rsp_err   <= lat_write && mismatch;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          Busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          Busy      <= 1'b0;
          ConfWrOut <= 1'b0;
        end
      endcase
    end
  end

endmodule
